// File: rtl/mips_cp0.sv
// Coprocessor 0 for the five-stage MIPS pipeline: SR, Cause, EPC, PRId and
// the flush/redirect request raised beside the M stage.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module mips_cp0 #(
   parameter logic [31:0] PRID_VALUE = 32'h0000_4D49,
   parameter int          TIMER_LINE = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   input  logic        cp0_we,
   output logic [31:0] cp0_rdata,
   input  logic [31:0] vpc,
   input  logic        bd_in,
   input  logic [4:0]  exc_code_in,
   input  logic [5:0]  hw_int,
   input  logic        eret,
   output logic        req,
   output logic [31:0] epc_out
);

   // SR fields
   logic [5:0]  im;
   logic        exl;
   logic        ie;
   // Cause fields
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;

   logic [5:0]  hw_eff;
   logic        int_req;
   logic        exc_req;
   logic        wr_ok;

`ifdef CP0_TIMER_EN
   logic [31:0] count;
   logic [31:0] compare;
   logic        timer_pending;
   logic        timer_hit;
   logic [5:0]  timer_mask;

   assign timer_hit = (count == compare);

   // Timer raises its line on the match cycle itself and stays up until Compare is rewritten
   always_comb begin
      timer_mask = '0;
      timer_mask[TIMER_LINE] = timer_pending | timer_hit;
   end

   assign hw_eff = hw_int | timer_mask;
`else
   assign hw_eff = hw_int;
`endif

   assign int_req = ie & ~exl & (|(hw_eff & im));
   assign exc_req = ~exl & (exc_code_in != 5'd0);
   assign req     = ~reset & (int_req | exc_req);
   // A taken exception swallows any mtc0 issued alongside it
   assign wr_ok   = cp0_we & ~req;

   // Forward a same-cycle mtc0 EPC so an adjacent eret fetches the new target
   assign epc_out = (wr_ok && cp0_addr == 5'd14) ? cp0_wdata : epc;

   // mfc0 read mux; shows register state before the current edge
   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         5'd12:   cp0_rdata = {16'b0, im, 8'b0, exl, ie};
         5'd13:   cp0_rdata = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
         5'd14:   cp0_rdata = epc;
         5'd15:   cp0_rdata = PRID_VALUE;
`ifdef CP0_TIMER_EN
         5'd9:    cp0_rdata = count;
         5'd11:   cp0_rdata = compare;
`endif
         default: cp0_rdata = '0;
      endcase
   end

   // Architectural state: exception entry beats mtc0/eret; eret beats mtc0 SR on EXL
   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         ip <= hw_eff;
         if (req) begin
            exl      <= 1'b1;
            exc_code <= int_req ? 5'd0 : exc_code_in;
            bd       <= bd_in;
            epc      <= bd_in ? vpc - 32'd4 : vpc;
         end else begin
            if (cp0_we && cp0_addr == 5'd12) begin
               im  <= cp0_wdata[15:10];
               exl <= cp0_wdata[1];
               ie  <= cp0_wdata[0];
            end
            if (cp0_we && cp0_addr == 5'd14)
               epc <= cp0_wdata;
            if (eret)
               exl <= 1'b0;
         end
      end
   end

`ifdef CP0_TIMER_EN
   // Free-running Count, Compare, and the sticky match flag
   always_ff @(posedge clk) begin
      if (reset) begin
         count         <= '0;
         compare       <= '0;
         timer_pending <= 1'b0;
      end else begin
         if (wr_ok && cp0_addr == 5'd9)
            count <= cp0_wdata;
         else
            count <= count + 32'd1;
         if (wr_ok && cp0_addr == 5'd11) begin
            compare       <= cp0_wdata;
            timer_pending <= 1'b0;
         end else if (timer_hit) begin
            timer_pending <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mips_cp0.sv
// Self-checking bench for mips_cp0: directed scenarios plus randomized traffic
// against a register-level reference model. Define CP0_TIMER_EN to cover the timer.
module tb_mips_cp0;

   localparam logic [31:0] PRID = 32'h0000_4D49;
   localparam int          TL   = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic        cp0_we;
   logic [31:0] cp0_rdata;
   logic [31:0] vpc;
   logic        bd_in;
   logic [4:0]  exc_code_in;
   logic [5:0]  hw_int;
   logic        eret;
   logic        req;
   logic [31:0] epc_out;

   always #10 clk = ~clk;

   mips_cp0 #(.PRID_VALUE(PRID), .TIMER_LINE(TL)) dut (
      .clk(clk), .reset(reset), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
      .cp0_we(cp0_we), .cp0_rdata(cp0_rdata), .vpc(vpc), .bd_in(bd_in),
      .exc_code_in(exc_code_in), .hw_int(hw_int), .eret(eret), .req(req),
      .epc_out(epc_out)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: registers held as whole architectural words
   logic [31:0] m_sr, m_cause, m_epc;
   logic [31:0] m_count, m_cmp;
   logic        m_pend;

   function automatic logic [5:0] m_hw();
      logic [5:0] h;
      h = hw_int;
`ifdef CP0_TIMER_EN
      if (m_pend || m_count == m_cmp) h[TL] = 1'b1;
`endif
      return h;
   endfunction

   function automatic logic m_int();
      logic [5:0] im;
      im = m_sr[15:10];
      return m_sr[0] && !m_sr[1] && ((m_hw() & im) != 6'd0);
   endfunction

   function automatic logic m_req();
      return !reset && (m_int() || (!m_sr[1] && exc_code_in != 5'd0));
   endfunction

   function automatic logic [31:0] m_rd();
      case (cp0_addr)
         5'd12: return m_sr;
         5'd13: return m_cause;
         5'd14: return m_epc;
         5'd15: return PRID;
`ifdef CP0_TIMER_EN
         5'd9:  return m_count;
         5'd11: return m_cmp;
`endif
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] m_epco();
      return (cp0_we && cp0_addr == 5'd14 && !m_req()) ? cp0_wdata : m_epc;
   endfunction

   task automatic m_update();
      logic        r, i, w, hit;
      logic [5:0]  h;
      r   = m_req();
      i   = m_int();
      h   = m_hw();
      w   = cp0_we && !r;
      hit = (m_count == m_cmp);
      if (reset) begin
         m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_cmp = 0; m_pend = 0;
         return;
      end
      m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, h} << 10);
      if (r) begin
         m_sr    = m_sr | 32'h2;
         m_cause = (m_cause & 32'h7FFF_FF83) | ({31'd0, bd_in} << 31)
                   | ({27'd0, (i ? 5'd0 : exc_code_in)} << 2);
         m_epc   = bd_in ? vpc - 32'd4 : vpc;
      end else begin
         if (w && cp0_addr == 5'd12) m_sr = cp0_wdata & 32'h0000_FC03;
         if (w && cp0_addr == 5'd14) m_epc = cp0_wdata;
         if (eret) m_sr = m_sr & ~32'h2;
      end
      if (w && cp0_addr == 5'd9) m_count = cp0_wdata;
      else                       m_count = m_count + 1;
      if (w && cp0_addr == 5'd11) begin
         m_cmp  = cp0_wdata;
         m_pend = 1'b0;
      end else if (hit) begin
         m_pend = 1'b1;
      end
   endtask

   // One clock: check combinational outputs, then advance DUT and model together
   task automatic cyc();
      #1;
      chk("req", {31'd0, req}, {31'd0, m_req()});
      chk("rdata", cp0_rdata, m_rd());
      chk("epc_out", epc_out, m_epco());
      @(posedge clk);
      m_update();
      @(negedge clk);
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] mask,
                     input logic [31:0] exp);
      cp0_addr = a;
      #1;
      chk(tag, cp0_rdata & mask, exp);
   endtask

   task automatic idle();
      cp0_we = 0; eret = 0; exc_code_in = 0; hw_int = 0; bd_in = 0;
   endtask

   // Cause checks ignore the timer's IP bit so directed values hold in both builds
   localparam logic [31:0] CMASK = ~(32'h1 << (10 + TL));

   initial begin
      bit hit;
      reset = 1; cp0_addr = 0; cp0_wdata = 0; vpc = 0;
      idle();
      m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_cmp = 0; m_pend = 0;
      exc_code_in = 5'd10;
      @(negedge clk);
      #1 chk("req_in_reset", {31'd0, req}, 32'd0);
      cyc(); cyc();
      reset = 0; exc_code_in = 0;
      rd("rst_sr", 12, 32'hFFFF_FFFF, 0);
      rd("rst_cause", 13, CMASK, 0);
      rd("rst_epc", 14, 32'hFFFF_FFFF, 0);
      rd("prid", 15, 32'hFFFF_FFFF, PRID);
      cyc();

      // interrupt entry
      cp0_we = 1; cp0_addr = 12; cp0_wdata = 32'h0000_0401;
      cyc();
      idle(); hw_int = 6'b000001; vpc = 32'h0000_3010;
      #1 chk("int_req", {31'd0, req}, 1);
      cyc();
      hw_int = 0;
      rd("int_sr", 12, 32'hFFFF_FFFF, 32'h0000_0403);
      rd("int_cause", 13, CMASK, 32'h0000_0400);
      rd("int_epc", 14, 32'hFFFF_FFFF, 32'h0000_3010);
      chk("int_req_after", {31'd0, req}, 0);
      eret = 1; cyc(); eret = 0;

      // overflow in a delay slot
      exc_code_in = 5'd12; bd_in = 1; vpc = 32'h0000_3024;
      #1 chk("ov_req", {31'd0, req}, 1);
      cyc();
      idle();
      rd("ov_cause", 13, CMASK, 32'h8000_0030);
      rd("ov_epc", 14, 32'hFFFF_FFFF, 32'h0000_3020);
      eret = 1; cyc(); eret = 0;

      // interrupt beats exception, write dropped
      hw_int = 6'b000001; exc_code_in = 5'd4; vpc = 32'h0000_3040;
      cp0_we = 1; cp0_addr = 14; cp0_wdata = 32'hDEAD_BEEF;
      #1 chk("pri_epc_out", epc_out, 32'h0000_3020);
      cyc();
      idle();
      rd("pri_exccode", 13, 32'h0000_007C, 0);
      rd("pri_epc", 14, 32'hFFFF_FFFF, 32'h0000_3040);
      eret = 1; cyc(); eret = 0;

      // mtc0 EPC alongside eret inside a handler
      exc_code_in = 5'd8; vpc = 32'h0000_3200;
      cyc();
      idle();
      cp0_we = 1; cp0_addr = 14; cp0_wdata = 32'h0000_3100; eret = 1;
      #1 chk("eret_bypass", epc_out, 32'h0000_3100);
      cyc();
      idle();
      rd("eret_exl", 12, 32'h2, 0);
      rd("eret_epc", 14, 32'hFFFF_FFFF, 32'h0000_3100);
      cyc();

`ifdef CP0_TIMER_EN
      reset = 1; cyc(); reset = 0;
      cp0_we = 1; cp0_addr = 11; cp0_wdata = 20; cyc();
      cp0_addr = 9; cp0_wdata = 0; cyc();
      cp0_addr = 12; cp0_wdata = 32'h0000_8001; cyc();
      idle(); cp0_addr = 9;
      hit = 0;
      for (int k = 0; k < 40 && !hit; k++) begin
         #1;
         if (req === 1'b1) begin
            chk("timer_count_at_req", cp0_rdata, 20);
            hit = 1;
         end
         cyc();
      end
      chk("timer_req_seen", {31'd0, hit}, 1);
      cp0_we = 1; cp0_addr = 11; cp0_wdata = 100; cyc();
      idle(); eret = 1; cyc(); eret = 0;
      for (int k = 0; k < 5; k++) begin
         #1 chk("timer_quiet", {31'd0, req}, 0);
         cyc();
      end
`endif

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         reset       = ($urandom_range(0, 99) == 0);
         cp0_addr    = 5'($urandom_range(8, 16));
         cp0_wdata   = $urandom;
         cp0_we      = ($urandom_range(0, 3) == 0);
         eret        = ($urandom_range(0, 5) == 0);
         exc_code_in = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         hw_int      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
         bd_in       = 1'($urandom);
         vpc         = $urandom;
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_cp0.md
Name: mips_cp0

Overview:
- Coprocessor 0 for the five-stage MIPS pipeline. It is the producing end of the exception/flush interface that the pipeline registers consume.
- Sits beside the M stage. It takes the M-stage PC, branch-delay flag, exception code, mtc0/mfc0 accesses, eret and the six hardware interrupt lines.
- It raises `req`, which flushes all pipeline registers and redirects fetch to the handler.
- It holds SR, Cause, EPC and PRId, and supplies EPC for eret.

Parameters:
- PRID_VALUE, 32'h0000_4D49, read-only value returned by register 15.
- TIMER_LINE, 5, index into IP[7:2] used by the optional timer interrupt.

Ports:
- clk  in  1  clock
- reset  in  1  reset (synchronous, active-high)
- cp0_addr  in  5  register number for mfc0/mtc0 (rd field)
- cp0_wdata  in  32  mtc0 write data (GPR rt, forwarded)
- cp0_we  in  1  mtc0 in M stage
- cp0_rdata  out  32  mfc0 read data, combinational
- vpc  in  32  PC of the M-stage instruction
- bd_in  in  1  M-stage instruction is in a delay slot
- exc_code_in  in  5  pending exception code of the M-stage instruction; 0 = none
- hw_int  in  6  external interrupt lines, level-sensitive
- eret  in  1  eret in M stage
- req  out  1  flush/redirect request, combinational
- epc_out  out  32  EPC to fetch for eret

Behaviour:
- Clock and reset: all state updates on posedge clk. reset is synchronous, active-high.
- Reset values: SR = 0, Cause = 0, EPC = 0, Count/Compare = 0 (when the optional feature is enabled). req = 0 while reset = 1.
- SR (register 12):
  - IM = bits [15:10], EXL = bit 1, IE = bit 0.
  - All other bits read 0.
  - Only IM, EXL and IE are writable by mtc0.
- Cause (register 13):
  - BD = bit 31, IP = bits [15:10], ExcCode = bits [6:2].
  - Not writable by mtc0.
  - IP samples hw_int every cycle, including while EXL = 1.
- EPC (register 14): fully writable by mtc0.
- PRId (register 15): returns PRID_VALUE.
- Any other address reads 0; writes to it are ignored.
- Request logic:
  - int_req = IE & ~EXL & |(hw_int & IM).
  - exc_req = ~EXL & (exc_code_in != 0).
  - req = ~reset & (int_req | exc_req).
  - Interrupt has priority over exception.
- On a cycle with req = 1, at the next edge:
  - EXL <= 1.
  - ExcCode <= int_req ? 0 : exc_code_in.
  - BD <= bd_in.
  - EPC <= bd_in ? vpc - 32'd4 (32-bit wrap) : vpc. vpc is stored unaligned for AdEL on fetch.
- Precedence: req beats a simultaneous cp0_we (the write is dropped) and a simultaneous eret.
- eret with req = 0: EXL <= 0 at the next edge. An eret with no exception pending never asserts req itself.
- mtc0 with req = 0: the write takes effect at the next edge. If it targets SR and eret is also high, eret's EXL clear wins and the IM/IE bits are still written.
- epc_out = (cp0_we & cp0_addr == 14 & ~req) ? cp0_wdata : EPC. This bypass lets an "mtc0 EPC; eret" pair in adjacent stages work.
- cp0_rdata reflects register state before the current edge; there is no internal write bypass on reads.
- Reset mid-handler: all state clears, so EXL = 0.
- Latency: req is the same cycle as the cause. CP0 state is updated one cycle later.

Optional Feature:
- Macro: CP0_TIMER_EN.
- When defined, the block adds:
  - Count (register 9): +1 every cycle, 32-bit wrap, writable by mtc0.
  - Compare (register 11): writable by mtc0.
  - Sticky timer_pending: set when Count == Compare, cleared by any mtc0 to Compare.
- timer_pending is ORed into hw_int[TIMER_LINE] for both IP and int_req.
- When not defined: registers 9 and 11 read 0, writes are ignored, and hw_int is used unmodified.

Test Plan:
- Reset, then mfc0 addresses 12/13/14/15 -> 0, 0, 0, PRID_VALUE; req = 0 even with exc_code_in = 5'd10 held during reset.
- mtc0 SR = 32'h0000_0401, then hw_int = 6'b000001, vpc = 32'h0000_3010 -> req = 1 that cycle; next cycle EXL = 1, ExcCode = 0, EPC = 32'h0000_3010, req = 0.
- exc_code_in = 5'd12 (Ov), bd_in = 1, vpc = 32'h0000_3024 -> req = 1; then Cause = 32'h8000_0030, EPC = 32'h0000_3020.
- Same cycle: interrupt enabled and pending, exc_code_in = 5'd4, cp0_we to EPC -> ExcCode = 0, write dropped, EPC = vpc.
- mtc0 EPC = 32'h0000_3100 with eret in the same cycle -> epc_out = 32'h0000_3100 combinationally; next cycle EXL = 0, EPC = 32'h0000_3100.
- CP0_TIMER_EN: SR = 32'h0000_8001, Compare = 20, Count = 0 -> req at Count = 20; mtc0 Compare = 100 clears the pending bit, and req stays 0 after eret.
